// File: rtl/uart_prog_pkg.sv
// Shared types and defaults for the UART boot-programming sequencer.
package uart_prog_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
      DONE,
      ERR
   } prog_state_e;

   localparam logic [31:0] END_WORD_DEF    = 32'h0000_0FFF;
   localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;

endpackage

// File: rtl/prog_byte_assembler.sv
// Collects UART bytes into little-endian 32-bit words and watches the
// idle gap between bytes of a partially received word.
module prog_byte_assembler #(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_next_o,
   output logic [31:0] word_o,
   output logic        timeout_o
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    byte_cnt_reg;
   logic [31:0]   word_reg;
   logic [TW-1:0] timer_reg;
   logic          take;

   assign take = en_i & rx_valid_i;

   // Byte lane gi is loaded when it is the slot the byte counter points at.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next_o[8*gi +: 8] = (take && byte_cnt_reg == 2'(gi)) ? rx_byte_i
                                                                      : word_reg[8*gi +: 8];
   end

   assign word_valid_o = take & (byte_cnt_reg == 2'd3);
   // A byte arriving in the expiry cycle wins over the timeout.
   assign timeout_o    = en_i & ~rx_valid_i & (byte_cnt_reg != 2'd0) &
                         (timer_reg == TW'(TIMEOUT_CYC - 1));
   assign word_o       = word_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         byte_cnt_reg <= '0;
         word_reg     <= '0;
         timer_reg    <= '0;
      end else if (clear_i) begin
         byte_cnt_reg <= '0;
         word_reg     <= '0;
         timer_reg    <= '0;
      end else begin
         word_reg <= word_next_o;
         if (take) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            timer_reg    <= '0;
         end else if (en_i && byte_cnt_reg != 2'd0) begin
            timer_reg <= timer_reg + TW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_prog_ctrl.sv
// Boot-programming sequencer: UART bytes -> 32-bit instruction-memory writes,
// holding the core in reset until the end-marker word arrives.
module uart_prog_ctrl
   import uart_prog_pkg::*;
#(
   parameter int              AW          = 32,
   parameter logic [AW-1:0]   BASE_ADDR   = '0,
   parameter logic [AW-1:0]   MEM_BYTES   = AW'(32'h0000_2000),
   parameter logic [31:0]     END_WORD    = END_WORD_DEF,
   parameter int unsigned     TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          prog_i,
   input  logic          rx_valid_i,
   input  logic [7:0]    rx_byte_i,
   output logic          mem_req_o,
   input  logic          mem_gnt_i,
   output logic          mem_we_o,
   output logic [3:0]    mem_be_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   output logic          core_rst_no,
   output logic          done_o,
   output logic          err_o
);

   localparam logic [AW:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

   prog_state_e   state_reg, state_next;
   logic [AW-1:0] addr_reg, addr_next;
   logic          prog_q_reg;
   logic          prog_rise, prog_fall, start;
   logic          word_valid, timeout;
   logic [31:0]   word_next, word;

   assign prog_rise = prog_i & ~prog_q_reg;
   assign prog_fall = ~prog_i & prog_q_reg;

   prog_byte_assembler #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_asm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (start),
      .en_i         (state_reg == RECV),
      .rx_valid_i   (rx_valid_i),
      .rx_byte_i    (rx_byte_i),
      .word_valid_o (word_valid),
      .word_next_o  (word_next),
      .word_o       (word),
      .timeout_o    (timeout)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= IDLE;
         addr_reg   <= BASE_ADDR;
         prog_q_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         addr_reg   <= addr_next;
         prog_q_reg <= prog_i;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      start      = 1'b0;
      case (state_reg)
         IDLE, DONE, ERR: begin
            if (prog_rise) begin
               state_next = RECV;
               addr_next  = BASE_ADDR;
               start      = 1'b1;
            end
         end
         RECV: begin
            if (prog_fall) begin
               state_next = ERR;
            end else if (word_valid) begin
               if (word_next == END_WORD)
                  state_next = DONE;
               else if ({1'b0, addr_reg} >= ADDR_LIMIT)
                  state_next = ERR;
               else
                  state_next = WRITE;
            end else if (timeout) begin
               state_next = ERR;
            end
         end
         WRITE: begin
            // Overrun beats a same-cycle grant; the request is simply dropped.
            if (prog_fall || rx_valid_i) begin
               state_next = ERR;
            end else if (mem_gnt_i) begin
               state_next = RECV;
               addr_next  = addr_reg + AW'(4);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode straight from the state register so reset clears them at once.
   assign mem_req_o   = (state_reg == WRITE);
   assign mem_we_o    = mem_req_o;
   assign mem_be_o    = mem_req_o ? 4'hF : 4'h0;
   assign mem_addr_o  = mem_req_o ? addr_reg : '0;
   assign mem_wdata_o = mem_req_o ? word : '0;
   assign core_rst_no = (state_reg == IDLE) || (state_reg == DONE);
   assign done_o      = (state_reg == DONE);
   assign err_o       = (state_reg == ERR);

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Randomised scoreboard bench for uart_prog_ctrl: a word-level model predicts
// each memory write, a monitor checks requests as the DUT presents them.
module tb_uart_prog_ctrl;

   localparam int          AW   = 32;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [31:0] MEMB = 32'h0000_0010;
   localparam logic [31:0] ENDW = 32'h0000_0FFF;
   localparam int          TC   = 20;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          prog = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          mem_gnt = 1'b0;
   logic          mem_req_o, mem_we_o, core_rst_no, done_o, err_o;
   logic [3:0]    mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        sb[$];
   logic [7:0] m_bytes[$];
   logic [31:0] m_addr = BASE;
   int pass_cnt = 0;
   int total_cnt = 0;
   int gnt_mode = 2;   // 0: tied high, 1: after gnt_delay request cycles, 2: withheld
   int gnt_delay = 0;
   int req_cnt = 0;
   int req_len = 0;

   uart_prog_ctrl #(
      .AW          (AW),
      .BASE_ADDR   (BASE),
      .MEM_BYTES   (MEMB),
      .END_WORD    (ENDW),
      .TIMEOUT_CYC (TC)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .prog_i      (prog),
      .rx_valid_i  (rx_valid),
      .rx_byte_i   (rx_byte),
      .mem_req_o   (mem_req_o),
      .mem_gnt_i   (mem_gnt),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .core_rst_no (core_rst_no),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Memory-side grant behaviour
   always @(posedge clk) begin
      #1;
      if (gnt_mode == 0) mem_gnt = 1'b1;
      else if (gnt_mode == 2) mem_gnt = 1'b0;
      else if (mem_req_o) begin
         mem_gnt = (req_cnt >= gnt_delay);
         req_cnt++;
      end else begin
         mem_gnt = 1'b0;
         req_cnt = 0;
      end
   end

   // Monitor: every request cycle must match the oldest owed write
   always @(negedge clk) begin
      if (mem_req_o) begin
         req_len++;
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_req: got addr 0x%08h data 0x%08h, expected no request",
                     mem_addr_o, mem_wdata_o);
         end else begin
            check("wr_addr", mem_addr_o, sb[0].addr);
            check("wr_data", mem_wdata_o, sb[0].data);
            check("wr_we_be", {27'b0, mem_we_o, mem_be_o}, 32'h0000_001F);
            if (mem_gnt) begin
               if (gnt_mode == 0) check("req_len", req_len, 1);
               $display("write addr=0x%08h data=0x%08h (%0d req cycles)",
                        mem_addr_o, mem_wdata_o, req_len);
               void'(sb.pop_front());
            end
         end
         if (mem_gnt) req_len = 0;
      end else begin
         req_len = 0;
      end
   end

   // Word-level reference: outcome 0 partial, 1 write, 2 done, 3 window error
   task automatic model_byte(input logic [7:0] b, output int outcome);
      logic [31:0] w;
      wr_t e;
      m_bytes.push_back(b);
      outcome = 0;
      if (m_bytes.size() == 4) begin
         w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
         m_bytes.delete();
         if (w == ENDW) outcome = 2;
         else if (m_addr >= BASE + MEMB) outcome = 3;
         else begin
            e.addr = m_addr;
            e.data = w;
            sb.push_back(e);
            m_addr = m_addr + 32'd4;
            outcome = 1;
         end
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output int outcome);
      int guard = 0;
      while (mem_req_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (mem_req_o) begin
         total_cnt++;
         $display("FAIL req_drain: got mem_req_o=1 after 100 cycles, expected grant");
      end
      model_byte(b, outcome);
      strobe(b);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps, output int outcome);
      for (int i = 0; i < 4; i++) begin
         if (gaps && i != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_byte(w[8*i +: 8], outcome);
      end
   endtask

   task automatic post_word(input string name, input int o);
      check(name, {28'b0, mem_req_o, done_o, err_o, core_rst_no},
            {28'b0, o == 1, o == 2, o == 3, o == 2});
   endtask

   task automatic session_start();
      prog = 1'b0;
      @(negedge clk);
      prog = 1'b1;
      @(negedge clk);
      m_addr = BASE;
      m_bytes.delete();
      check("start_status", {29'b0, done_o, err_o, core_rst_no}, 32'h0);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {24'b0, mem_req_o, mem_we_o, mem_be_o, done_o, err_o}, 32'h0);
      check({name, "_core"}, core_rst_no, 1);
      check({name, "_addr"}, mem_addr_o, 0);
      check({name, "_wdata"}, mem_wdata_o, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish within time limit, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int o;
      logic [31:0] w;
      logic [7:0] dir_bytes[12] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE,
                                    8'hAD, 8'hDE, 8'hFF, 8'h0F, 8'h00, 8'h00};

      repeat (3) @(negedge clk);
      check_reset_outputs("reset_hold");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset_idle");

      // Directed image, grant after two request cycles
      gnt_mode = 1; gnt_delay = 2;
      session_start();
      foreach (dir_bytes[i]) begin
         send_byte(dir_bytes[i], o);
         if (i % 4 == 3) post_word("dir_word", o);
      end
      repeat (10) @(negedge clk);
      check("dir_owed", sb.size(), 0);

      // Grant tied high: single-cycle writes at 0x0, 0x4, 0x8
      gnt_mode = 0;
      session_start();
      for (int k = 0; k < 3; k++) begin
         w = $urandom;
         if (w == ENDW) w = ~w;
         send_word(w, 1'b1, o);
         post_word("gnt_high_word", o);
      end
      send_word(ENDW, 1'b0, o);
      post_word("gnt_high_end", o);

      // Inter-byte timeout, then recovery at BASE_ADDR
      gnt_mode = 1; gnt_delay = 1;
      session_start();
      send_byte(8'hA5, o);
      send_byte(8'h5A, o);
      repeat (TC - 1) @(negedge clk);
      check("timeout_early", err_o, 0);
      @(negedge clk);
      check("timeout_err", {30'b0, err_o, core_rst_no}, 32'h2);
      session_start();
      send_word(32'hCAFE_0001, 1'b1, o);
      post_word("recover_word", o);
      send_word(ENDW, 1'b0, o);
      post_word("recover_end", o);

      // Overrun: byte while the write is still ungranted
      gnt_mode = 2;
      session_start();
      send_word(32'h1111_2222, 1'b0, o);
      post_word("overrun_word", o);
      repeat (2) @(negedge clk);
      strobe(8'h33);
      check("overrun", {30'b0, err_o, mem_req_o}, 32'h2);
      void'(sb.pop_back());

      // Window full: four writes fit, the fifth word errors without a request
      gnt_mode = 1; gnt_delay = 0;
      session_start();
      for (int k = 0; k < 5; k++) begin
         w = $urandom;
         if (w == ENDW) w = ~w;
         send_word(w, 1'b1, o);
         post_word("window_word", o);
      end
      check("window_err", {30'b0, err_o, mem_req_o}, 32'h2);

      // Abort mid-word
      session_start();
      send_byte(8'h01, o);
      send_byte(8'h02, o);
      prog = 1'b0;
      @(negedge clk);
      check("abort_recv", {30'b0, err_o, core_rst_no}, 32'h2);

      // Abort during WRITE
      gnt_mode = 2;
      session_start();
      send_word(32'h0BAD_F00D, 1'b0, o);
      prog = 1'b0;
      @(negedge clk);
      check("abort_write", {30'b0, err_o, mem_req_o}, 32'h2);
      void'(sb.pop_back());

      // Asynchronous reset while a request is pending
      session_start();
      send_word(32'h7777_8888, 1'b0, o);
      check("pre_reset_req", mem_req_o, 1);
      #2;
      rst_n = 1'b0;
      prog  = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      void'(sb.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_reset");

      // Randomised sessions
      for (int s = 0; s < 8; s++) begin
         gnt_mode  = $urandom_range(0, 1);
         gnt_delay = $urandom_range(0, 3);
         session_start();
         o = 0;
         for (int k = 0; k < 6 && o < 2; k++) begin
            if ($urandom_range(0, 3) == 0) w = ENDW;
            else begin
               w = $urandom;
               if (w == ENDW) w = ~w;
            end
            send_word(w, 1'b1, o);
            post_word("rand_word", o);
         end
      end

      repeat (10) @(negedge clk);
      check("final_owed", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
